// File: rtl/tcpc_reset_ctrl_pkg.sv
// ----------------------------------------------------------------------------
// tcpc_reset_ctrl_pkg
//   Shared definitions for the TCPC Hard/Cable Reset sequencer.
//   - TRANSMIT SOP* type codes that request a reset transmission
//   - ALERT register bit positions touched by the sequencer
//   - sequencer state encoding
//   - isResetType(): true for the two reset request codes
// ----------------------------------------------------------------------------
package tcpc_reset_ctrl_pkg;

  // TRANSMIT[2:0] codes that ask the PHY to send a reset signalling
  localparam logic [2:0] TX_HARD_RESET  = 3'b101;
  localparam logic [2:0] TX_CABLE_RESET = 3'b110;

  // ALERT register bit indices related to transmission outcome
  localparam int ALERT_TX_FAILED_BIT    = 4;
  localparam int ALERT_TX_DISCARDED_BIT = 5;
  localparam int ALERT_TX_SUCCESS_BIT   = 6;

  // Sequencer states
  typedef enum logic [1:0] {
    IDLE     = 2'd0,
    CLEAR    = 2'd1,
    SENDING  = 2'd2,
    COMPLETE = 2'd3
  } seqState_t;

  // True when a SOP* type field encodes a Hard Reset or Cable Reset request
  function automatic logic isResetType(input logic [2:0] sopType);
    return (sopType == TX_HARD_RESET) || (sopType == TX_CABLE_RESET);
  endfunction

endpackage

// File: rtl/tcpc_reset_ctrl_reset_timer.sv
// ----------------------------------------------------------------------------
// tcpc_reset_ctrl_reset_timer
//   Synchronous up-counter that times the reset transmission.
//   load clears the count, enable advances it; the count saturates at
//   CYCLES-1 and 'terminal' is high while it sits there.
// Ports
//   CLK       in   clock, rising edge
//   reset     in   synchronous active-high reset (count -> 0)
//   load      in   restart the count from 0 (priority over enable)
//   enable    in   advance the count by one
//   terminal  out  count == CYCLES-1
// ----------------------------------------------------------------------------
module tcpc_reset_ctrl_reset_timer #(
  parameter int CYCLES = 16,
  parameter int WIDTH  = (CYCLES > 2) ? $clog2(CYCLES) : 1
) (
  input  logic CLK,
  input  logic reset,
  input  logic load,
  input  logic enable,
  output logic terminal
);

  localparam logic [WIDTH-1:0] LAST = WIDTH'(CYCLES - 1);

  logic [WIDTH-1:0] count;

  // NOTE: registers are updated with non-blocking assignments so every flop
  // samples values from before the edge, independent of statement order.
  always_ff @(posedge CLK) begin
    if (reset) begin
      count <= '0;
    end else if (load) begin
      count <= '0;
    end else if (enable && (count != LAST)) begin
      // Saturate at LAST so a late enable can never wrap back to zero
      count <= count + 1'b1;
    end
  end

  assign terminal = (count == LAST);

endmodule

// File: rtl/tcpc_reset_ctrl.sv
// ----------------------------------------------------------------------------
// tcpc_reset_ctrl
//   Hard/Cable Reset sequencer of the USB-PD TCPC, between the register file
//   and the PHY. A new Hard or Cable Reset request in TRANSMIT disables
//   reception, the reset transmission is timed for HARD_RESET_CYCLES clocks,
//   then completion is posted into ALERT, TRANSMIT is cleared and the PHY is
//   told to stop. Outside of that, TRANSMIT and ALERT pass through registered.
// Parameters
//   HARD_RESET_CYCLES  reset transmission length in CLK cycles (>= 2)
//   ALERT_TX_OK_BIT    ALERT bit set on completion
// Ports
//   CLK                        in   clock, all logic on rising edge
//   reset                      in   synchronous active-high reset
//   ioTRANSMIT                 in   current TRANSMIT value, [2:0] = SOP* type
//   iAlert                     in   current ALERT value
//   oTRANSMIT                  out  TRANSMIT written back to the register file
//   ALERT                      out  ALERT written back to the register file
//   oRECEIVE_DETECT            out  RECEIVE_DETECT forced by this block (0)
//   oRECEIVE_BYTE_COUNT        out  RECEIVE_BYTE_COUNT forced by this block (0)
//   PHY_Stop_Attempting_Reset  out  one-cycle pulse when the sequence completes
// ----------------------------------------------------------------------------
module tcpc_reset_ctrl
  import tcpc_reset_ctrl_pkg::*;
#(
  parameter int HARD_RESET_CYCLES = 16,
  parameter int ALERT_TX_OK_BIT   = ALERT_TX_SUCCESS_BIT
) (
  input  logic        CLK,
  input  logic        reset,
  input  logic [7:0]  ioTRANSMIT,
  input  logic [15:0] iAlert,
  output logic [7:0]  oTRANSMIT,
  output logic [15:0] ALERT,
  output logic [7:0]  oRECEIVE_DETECT,
  output logic [7:0]  oRECEIVE_BYTE_COUNT,
  output logic        PHY_Stop_Attempting_Reset
);

  localparam logic [15:0] TX_OK_MASK = 16'h0001 << ALERT_TX_OK_BIT;

  seqState_t  state;
  logic [2:0] prevType;
  logic       startReq;
  logic       timerLoad;
  logic       timerEnable;
  logic       timerDone;

  // Edge-qualified request: a reset code counts only when the previous cycle
  // did not already carry one, so a held value never retriggers.
  assign startReq = isResetType(ioTRANSMIT[2:0]) && !isResetType(prevType);

  assign timerLoad   = (state == CLEAR);
  assign timerEnable = (state == SENDING);

  tcpc_reset_ctrl_reset_timer #(
    .CYCLES (HARD_RESET_CYCLES)
  ) u_timer (
    .CLK      (CLK),
    .reset    (reset),
    .load     (timerLoad),
    .enable   (timerEnable),
    .terminal (timerDone)
  );

  // NOTE: prevType deliberately has no reset branch: it keeps sampling
  // TRANSMIT while reset is asserted, so a reset code held across reset
  // release (or across an abort) is seen as old and does not start a
  // sequence.
  always_ff @(posedge CLK) begin
    prevType <= ioTRANSMIT[2:0];
  end

  always_ff @(posedge CLK) begin
    if (reset) begin
      state                     <= IDLE;
      oTRANSMIT                 <= '0;
      ALERT                     <= '0;
      oRECEIVE_DETECT           <= '0;
      oRECEIVE_BYTE_COUNT       <= '0;
      PHY_Stop_Attempting_Reset <= 1'b0;
    end else begin
      // Reception stays disabled in every state
      oRECEIVE_DETECT     <= '0;
      oRECEIVE_BYTE_COUNT <= '0;

      unique case (state)
        IDLE: begin
          oTRANSMIT                 <= ioTRANSMIT;
          ALERT                     <= iAlert;
          PHY_Stop_Attempting_Reset <= 1'b0;
          if (startReq) begin
            state <= CLEAR;
          end
        end

        CLEAR: begin
          // The timer is loaded from this state; pass-through carries on
          oTRANSMIT                 <= ioTRANSMIT;
          ALERT                     <= iAlert;
          PHY_Stop_Attempting_Reset <= 1'b0;
          state                     <= SENDING;
        end

        SENDING: begin
          // New TRANSMIT writes are reflected but never restart the timer
          oTRANSMIT                 <= ioTRANSMIT;
          ALERT                     <= iAlert;
          PHY_Stop_Attempting_Reset <= 1'b0;
          if (timerDone) begin
            state <= COMPLETE;
          end
        end

        COMPLETE: begin
          // OR-set only: bits already pending in ALERT are preserved, and the
          // current iAlert is used so a same-cycle update is not lost
          oTRANSMIT                 <= 8'h00;
          ALERT                     <= iAlert | TX_OK_MASK;
          PHY_Stop_Attempting_Reset <= 1'b1;
          state                     <= IDLE;
        end

        default: begin
          state <= IDLE;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_tcpc_reset_ctrl.sv
// ----------------------------------------------------------------------------
// tb_tcpc_reset_ctrl
//   Self-checking bench for tcpc_reset_ctrl. A behavioural model predicts the
//   outputs cycle by cycle from the sequencing rules (a sequence started at
//   clock N completes at clock N+2+HR); directed scenarios add literal
//   expectations, followed by a randomized run.
// ----------------------------------------------------------------------------
module tb_tcpc_reset_ctrl;

  localparam int HR = 16;

  logic        CLK;
  logic        reset;
  logic [7:0]  ioTRANSMIT;
  logic [15:0] iAlert;
  logic [7:0]  oTRANSMIT;
  logic [15:0] ALERT;
  logic [7:0]  oRECEIVE_DETECT;
  logic [7:0]  oRECEIVE_BYTE_COUNT;
  logic        PHY_Stop_Attempting_Reset;

  tcpc_reset_ctrl #(
    .HARD_RESET_CYCLES (HR),
    .ALERT_TX_OK_BIT   (6)
  ) dut (
    .CLK                       (CLK),
    .reset                     (reset),
    .ioTRANSMIT                (ioTRANSMIT),
    .iAlert                    (iAlert),
    .oTRANSMIT                 (oTRANSMIT),
    .ALERT                     (ALERT),
    .oRECEIVE_DETECT           (oRECEIVE_DETECT),
    .oRECEIVE_BYTE_COUNT       (oRECEIVE_BYTE_COUNT),
    .PHY_Stop_Attempting_Reset (PHY_Stop_Attempting_Reset)
  );

  initial CLK = 1'b0;
  always #5 CLK = ~CLK;

  int checks = 0;
  int errors = 0;
  int cyc    = 0;

  // Model state: whether a sequence is pending and the clock it completes on
  bit          mActive = 0;
  int          mDoneAt = 0;
  logic [2:0]  mPrev   = 3'b000;
  logic [7:0]  expTx    = 8'h00;
  logic [15:0] expAlert = 16'h0000;
  logic        expStop  = 1'b0;

  task automatic check(input string name, input logic [15:0] act, input logic [15:0] req);
    checks++;
    if (act !== req) begin
      errors++;
      $display("FAIL %s: got %h, expected %h (cycle %0d)", name, act, req, cyc);
    end
  endtask

  function automatic bit isRst(input logic [2:0] t);
    return (t == 3'd5) || (t == 3'd6);
  endfunction

  // Model update for one rising edge, using the inputs present at the edge
  task automatic modelStep();
    if (reset) begin
      expTx = 8'h00; expAlert = 16'h0000; expStop = 1'b0; mActive = 0;
    end else if (mActive && cyc == mDoneAt) begin
      expTx = 8'h00; expAlert = iAlert | 16'h0040; expStop = 1'b1; mActive = 0;
    end else begin
      expTx = ioTRANSMIT; expAlert = iAlert; expStop = 1'b0;
      if (!mActive && isRst(ioTRANSMIT[2:0]) && !isRst(mPrev)) begin
        mActive = 1;
        mDoneAt = cyc + HR + 2;
      end
    end
    mPrev = ioTRANSMIT[2:0];
  endtask

  task automatic compareAll();
    check("oTRANSMIT", {8'h00, oTRANSMIT}, {8'h00, expTx});
    check("ALERT", ALERT, expAlert);
    check("PHY_Stop", {15'd0, PHY_Stop_Attempting_Reset}, {15'd0, expStop});
    check("oRECEIVE_DETECT", {8'h00, oRECEIVE_DETECT}, 16'h0000);
    check("oRECEIVE_BYTE_COUNT", {8'h00, oRECEIVE_BYTE_COUNT}, 16'h0000);
  endtask

  // One clock: model advances at the edge, outputs compared 1 time unit later
  task automatic tick();
    @(posedge CLK);
    cyc++;
    modelStep();
    #1;
    compareAll();
  endtask

  // Advance n clocks and return how many PHY_Stop pulses were seen
  task automatic runCount(input int n, output int pulses);
    pulses = 0;
    for (int i = 0; i < n; i++) begin
      tick();
      pulses += int'(PHY_Stop_Attempting_Reset);
    end
  endtask

  int pulses;

  initial begin
    // 1. Reset with a reset code held; releasing must not start a sequence
    reset = 1'b1; ioTRANSMIT = 8'h05; iAlert = 16'hFFFF;
    tick(); tick();
    check("t1_tx_reset", {8'h00, oTRANSMIT}, 16'h0000);
    check("t1_alert_reset", ALERT, 16'h0000);
    check("t1_stop_reset", {15'd0, PHY_Stop_Attempting_Reset}, 16'h0000);
    reset = 1'b0;
    runCount(HR + 8, pulses);
    check("t1_no_start_after_reset", 16'(pulses), 16'd0);
    check("t1_passthrough_05", {8'h00, oTRANSMIT}, 16'h0005);

    // 2. Plain pass-through
    ioTRANSMIT = 8'h03; iAlert = 16'h0011;
    tick();
    check("t2_tx", {8'h00, oTRANSMIT}, 16'h0003);
    check("t2_alert", ALERT, 16'h0011);
    check("t2_stop", {15'd0, PHY_Stop_Attempting_Reset}, 16'h0000);

    // 3. Hard reset: completion lands HR+2 clocks after the start edge
    ioTRANSMIT = 8'h00; iAlert = 16'h0000;
    tick();
    ioTRANSMIT = 8'h05;
    tick();
    runCount(HR + 1, pulses);
    check("t3_no_early_stop", 16'(pulses), 16'd0);
    tick();
    check("t3_tx_cleared", {8'h00, oTRANSMIT}, 16'h0000);
    check("t3_alert_ok", ALERT, 16'h0040);
    check("t3_stop_pulse", {15'd0, PHY_Stop_Attempting_Reset}, 16'h0001);
    tick();
    check("t3_stop_one_cycle", {15'd0, PHY_Stop_Attempting_Reset}, 16'h0000);

    // 4. Cable reset with a second 06 write during SENDING
    ioTRANSMIT = 8'h00; iAlert = 16'h0001;
    tick();
    ioTRANSMIT = 8'h06;
    tick();                       // start edge N
    runCount(4, pulses);          // N+1..N+4
    ioTRANSMIT = 8'h00;
    tick();                       // N+5
    ioTRANSMIT = 8'h06;
    tick();                       // N+6: rewrite must be ignored
    runCount(HR - 5, pulses);     // N+7..N+1+HR
    check("t4_no_early_stop", 16'(pulses), 16'd0);
    tick();                       // N+2+HR
    check("t4_alert_ok", ALERT, 16'h0041);
    check("t4_stop_pulse", {15'd0, PHY_Stop_Attempting_Reset}, 16'h0001);
    runCount(HR + 8, pulses);
    check("t4_no_restart", 16'(pulses), 16'd0);

    // 5. Abort: reset during the 5th SENDING clock
    ioTRANSMIT = 8'h00; iAlert = 16'h0000;
    tick();
    ioTRANSMIT = 8'h05;
    tick();                       // start edge N
    runCount(5, pulses);          // N+1..N+5
    reset = 1'b1;
    tick();                       // N+6
    reset = 1'b0;
    check("t5_alert_abort", ALERT, 16'h0000);
    check("t5_tx_abort", {8'h00, oTRANSMIT}, 16'h0000);
    runCount(HR + 8, pulses);
    check("t5_no_stop_after_abort", 16'(pulses), 16'd0);

    // 6. SOP* type 111 never starts a sequence
    ioTRANSMIT = 8'h00;
    tick();
    ioTRANSMIT = 8'h07;
    runCount(HR + 6, pulses);
    check("t6_no_sequence", 16'(pulses), 16'd0);
    check("t6_passthrough", {8'h00, oTRANSMIT}, 16'h0007);

    // 7. Randomized traffic, checked every cycle by the model
    for (int i = 0; i < 4000; i++) begin
      int r;
      logic [2:0] t;
      r = int'($urandom_range(0, 99));
      if (r < 12) begin
        r = int'($urandom_range(0, 9));
        t = (r < 3) ? 3'd5 : (r < 6) ? 3'd6 : 3'($urandom);
        ioTRANSMIT = {5'($urandom), t};
      end
      if ($urandom_range(0, 3) == 0) iAlert = 16'($urandom);
      reset = ($urandom_range(0, 199) == 0);
      tick();
    end
    reset = 1'b0;

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
